// File: rtl/shift_reg_n.sv
// shift_reg_n: WIDTH-bit shift register with hold, parallel load, shift, and
// clear. It provides a serial output, a count of completed shifts, and a
// one-cycle done pulse that fires after every WIDTH-th shift of a word.
module shift_reg_n #(
    parameter int unsigned      WIDTH     = 8,
    parameter bit               LSB_FIRST = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int unsigned     CW        = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             sout,
    output logic [CW-1:0]    cnt,
    output logic             done
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_LOAD  = 2'b01,
        MODE_SHIFT = 2'b10,
        MODE_CLEAR = 2'b11
    } mode_e;

    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    mode_e            op;
    logic [WIDTH-1:0] q_r, q_nxt, shifted;
    logic [CW-1:0]    cnt_r, cnt_nxt;
    logic             done_r, done_nxt;

    assign op = mode_e'(mode);

    // Word after one shift step in the configured direction.
    always_comb begin
        shifted = q_r;
        if (LSB_FIRST) begin
            shifted = {sin, q_r[WIDTH-1:1]};
        end else begin
            shifted = {q_r[WIDTH-2:0], sin};
        end
    end

    // Next-state decode. Done fires only on the shift that completes a word.
    // Every other operation clears it.
    always_comb begin
        q_nxt    = q_r;
        cnt_nxt  = cnt_r;
        done_nxt = 1'b0;
        unique case (op)
            MODE_HOLD: begin
                q_nxt   = q_r;
                cnt_nxt = cnt_r;
            end
            MODE_LOAD: begin
                q_nxt   = d;
                cnt_nxt = '0;
            end
            MODE_SHIFT: begin
                q_nxt = shifted;
                if (cnt_r == LAST_CNT) begin
                    cnt_nxt  = '0;
                    done_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_r + 1'b1;
                end
            end
            MODE_CLEAR: begin
                q_nxt   = '0;
                cnt_nxt = '0;
            end
            default: begin
                q_nxt   = q_r;
                cnt_nxt = cnt_r;
            end
        endcase
    end

    // State registers with asynchronous reset to RESET_VAL and a zero count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r    <= RESET_VAL;
            cnt_r  <= '0;
            done_r <= 1'b0;
        end else begin
            q_r    <= q_nxt;
            cnt_r  <= cnt_nxt;
            done_r <= done_nxt;
        end
    end

    assign q    = q_r;
    assign qbar = ~q_r;
    assign sout = LSB_FIRST ? q_r[0] : q_r[WIDTH-1];
    assign cnt  = cnt_r;
    assign done = done_r;

endmodule

// File: doc/shift_reg_n.md
SHIFT_REG_N -- requirements
Module: shift_reg_n

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range 2..32.
REQ-002 Parameter LSB_FIRST, default 1; 1 = shift toward bit 0, 0 = shift toward bit WIDTH-1.
REQ-003 Parameter RESET_VAL, default 0 (WIDTH bits), register contents after reset.
REQ-004 Port clk  input  1  sole clock, all state on rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port mode  input  2  operation select: 00 hold, 01 parallel load, 10 shift, 11 clear.
REQ-007 Port d  input  WIDTH  parallel load data.
REQ-008 Port sin  input  1  serial input bit entering the register on shift.
REQ-009 Port q  output  WIDTH  registered contents.
REQ-010 Port qbar  output  WIDTH  bitwise complement of q.
REQ-011 Port sout  output  1  serial output bit, the bit that leaves on the next shift.
REQ-012 Port cnt  output  CW  shifts completed since the last load, clear or wrap; CW = $clog2(WIDTH), minimum 1.
REQ-013 Port done  output  1  registered one-cycle pulse marking completion of WIDTH shifts.

Function
REQ-014 mode 00 (hold): q and cnt unchanged; done low the next cycle.
REQ-015 mode 01 (load): q <= d; cnt <= 0; done low the next cycle.
REQ-016 mode 10 (shift), LSB_FIRST=1: q <= {sin, q[WIDTH-1:1]}.
REQ-017 mode 10 (shift), LSB_FIRST=0: q <= {q[WIDTH-2:0], sin}.
REQ-018 sout is combinational from current q: q[0] when LSB_FIRST=1, q[WIDTH-1] when LSB_FIRST=0.
REQ-019 qbar is combinational: qbar = ~q at all times, including during reset.
REQ-020 On each shift with cnt < WIDTH-1: cnt <= cnt+1; done low the next cycle.
REQ-021 On a shift with cnt == WIDTH-1: cnt <= 0 (wrap); done high for exactly the next cycle.
REQ-022 done is never high for two consecutive cycles unless the WIDTH-th shift of a new word lands on that cycle; with WIDTH >= 2 this cannot occur.
REQ-023 mode 11 (clear): q <= 0 (not RESET_VAL); cnt <= 0; done low the next cycle.
REQ-024 A load or clear issued after a partial shift sequence discards the partial count; no done is produced.
REQ-025 Mode changes take effect on the next rising edge; no mode requires a setup cycle.
REQ-026 Latency: every operation completes in one clock; q, cnt and done are registered.

Reset
REQ-027 While rst is high: q = RESET_VAL, cnt = 0, done = 0, independent of clk.
REQ-028 rst asserted mid-shift-sequence aborts it; after release cnt restarts from 0 and no done is emitted for the aborted word.
REQ-029 First operation is taken on the first rising edge after rst deasserts.

Verification
REQ-030 WIDTH=8, LSB_FIRST=1: load 8'hA5, then 8 shifts with sin=0 -> sout sequence 1,0,1,0,0,1,0,1; q=8'h00; done high only in the cycle after the 8th shift; cnt=0.
REQ-031 WIDTH=8, LSB_FIRST=0: load 8'h00, then 8 shifts with sin = 1,1,0,0,1,0,1,0 -> q=8'hCA; done pulses once.
REQ-032 Reset during shift: load 8'hFF, 3 shifts, assert rst between edges -> q=RESET_VAL and cnt=0 immediately; after release, 8 shifts give exactly one done pulse.
REQ-033 Abort via load: load, 5 shifts, load 8'h3C -> cnt=0, q=8'h3C, no done; 8 further shifts -> one done pulse.
REQ-034 Hold and clear: load 8'h5A, hold 4 cycles -> q=8'h5A, qbar=8'hA5, cnt unchanged; clear -> q=8'h00, qbar=8'hFF, cnt=0.
REQ-035 Back-to-back words: 16 consecutive shifts with WIDTH=8 -> done high in the cycles after shift 8 and after shift 16 only; cnt wraps to 0 both times.
